addr_seq_sched: RTL and testbench

Scheduler and sequencer for the 2-D affine address datapath: `offset + x*x_stride + y*y_stride`.

- Arbitrates round-robin between `NREQ` requesters, each presenting a complete sweep configuration.
- Latches the granted configuration and steps its own x/y stride accumulators, one address per accepted output beat.
- Emits the address stream with valid/ready backpressure, a requester tag and a last flag.
- Sits between job-issuing clients and the memory port that consumes addresses.

---
 rtl/addr_seq_sched_if.sv | 31 +++
 rtl/addr_seq_sched.sv | 124 ++++++++++++
 tb/tb_addr_seq_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_seq_sched_if.sv
// rtl/addr_seq_sched_if.sv - requester config and address stream bundle for addr_seq_sched
interface addr_seq_sched_if #(
   parameter int NREQ = 2,
   parameter int W    = 16,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_offset;
   logic [NREQ*W-1:0] req_x_max;
   logic [NREQ*W-1:0] req_x_stride;
   logic [NREQ*W-1:0] req_y_max;
   logic [NREQ*W-1:0] req_y_stride;
   logic              addr_valid;
   logic              addr_ready;
   logic [W-1:0]      addr_data;
   logic [IDW-1:0]    addr_id;
   logic              addr_last;

   modport master (
      output req_valid, req_offset, req_x_max, req_x_stride, req_y_max, req_y_stride,
      output addr_ready,
      input  req_ready, addr_valid, addr_data, addr_id, addr_last
   );

   modport slave (
      input  req_valid, req_offset, req_x_max, req_x_stride, req_y_max, req_y_stride,
      input  addr_ready,
      output req_ready, addr_valid, addr_data, addr_id, addr_last
   );
endinterface

// File: rtl/addr_seq_sched.sv
// rtl/addr_seq_sched.sv - round-robin job scheduler and 2-D affine address sequencer
module addr_seq_sched #(
   parameter int NREQ = 2,
   parameter int W    = 16,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   addr_seq_sched_if.slave  bus,
   output logic             busy
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;

   logic [IDW-1:0] last_grant, grant_idx, id_q;
   logic           found;
   int             cand;
   logic [W-1:0]   sel_offset, sel_x_max, sel_x_stride, sel_y_max, sel_y_stride;
   logic [W-1:0]   offset_q, x_max_q, x_stride_q, y_max_q, y_stride_q;
   logic [W-1:0]   x_cnt, y_cnt, x_acc, y_acc;
   logic [W-1:0]   nx_cnt, ny_cnt, nx_acc, ny_acc;
   logic           x_wrap, nxt_last;
   logic           valid_q, last_q;
   logic [W-1:0]   data_q;

   // Search upward from last_grant+1 with wrap; the first valid requester wins.
   always_comb begin
      found        = 1'b0;
      grant_idx    = '0;
      cand         = 0;
      sel_offset   = '0;
      sel_x_max    = '0;
      sel_x_stride = '0;
      sel_y_max    = '0;
      sel_y_stride = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(last_grant) + 1 + k) % NREQ;
         if (!found && bus.req_valid[cand]) begin
            found        = 1'b1;
            grant_idx    = IDW'(cand);
            sel_offset   = bus.req_offset[cand*W +: W];
            sel_x_max    = bus.req_x_max[cand*W +: W];
            sel_x_stride = bus.req_x_stride[cand*W +: W];
            sel_y_max    = bus.req_y_max[cand*W +: W];
            sel_y_stride = bus.req_y_stride[cand*W +: W];
         end
      end
   end

   always_comb begin
      x_wrap   = (x_cnt == x_max_q - W'(1));
      nx_cnt   = x_wrap ? '0 : x_cnt + W'(1);
      nx_acc   = x_wrap ? '0 : x_acc + x_stride_q;
      ny_cnt   = x_wrap ? y_cnt + W'(1) : y_cnt;
      ny_acc   = x_wrap ? y_acc + y_stride_q : y_acc;
      nxt_last = (nx_cnt == x_max_q - W'(1)) && (ny_cnt == y_max_q - W'(1));
   end

   assign bus.req_ready  = (state == IDLE && !rst && found) ? (NREQ'(1) << grant_idx) : '0;
   assign bus.addr_valid = valid_q;
   assign bus.addr_data  = data_q;
   assign bus.addr_id    = id_q;
   assign bus.addr_last  = last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         id_q       <= '0;
         offset_q   <= '0;
         x_max_q    <= '0;
         x_stride_q <= '0;
         y_max_q    <= '0;
         y_stride_q <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         x_acc      <= '0;
         y_acc      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               offset_q   <= sel_offset;
               x_max_q    <= sel_x_max;
               x_stride_q <= sel_x_stride;
               y_max_q    <= sel_y_max;
               y_stride_q <= sel_y_stride;
               id_q       <= grant_idx;
               last_grant <= grant_idx;
               x_cnt      <= '0;
               y_cnt      <= '0;
               x_acc      <= '0;
               y_acc      <= '0;
               // Zero-size jobs are consumed here and never leave IDLE.
               if (sel_x_max != '0 && sel_y_max != '0) begin
                  state   <= RUN;
                  valid_q <= 1'b1;
                  busy    <= 1'b1;
                  data_q  <= sel_offset;
                  last_q  <= (sel_x_max == W'(1)) && (sel_y_max == W'(1));
               end
            end
            RUN: if (bus.addr_ready) begin
               if (last_q) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  busy    <= 1'b0;
                  last_q  <= 1'b0;
               end else begin
                  x_cnt  <= nx_cnt;
                  y_cnt  <= ny_cnt;
                  x_acc  <= nx_acc;
                  y_acc  <= ny_acc;
                  data_q <= offset_q + nx_acc + ny_acc;
                  last_q <= nxt_last;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_addr_seq_sched.sv
// tb/tb_addr_seq_sched.sv - scoreboard bench for addr_seq_sched
module tb_addr_seq_sched;
   localparam int NREQ = 2;
   localparam int W    = 16;
   localparam int IDW  = 1;

   typedef struct packed {
      logic [W-1:0]   data;
      logic [IDW-1:0] id;
      logic           last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_pass  = 0;
   int   n_total = 0;
   beat_t exp_q[$];

   addr_seq_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

   addr_seq_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [W-1:0] off, input logic [W-1:0] xm,
                          input logic [W-1:0] xs, input logic [W-1:0] ym, input logic [W-1:0] ys);
      bus.req_offset[i*W +: W]   = off;
      bus.req_x_max[i*W +: W]    = xm;
      bus.req_x_stride[i*W +: W] = xs;
      bus.req_y_max[i*W +: W]    = ym;
      bus.req_y_stride[i*W +: W] = ys;
      bus.req_valid[i]           = 1'b1;
   endtask

   task automatic push_beat(input logic [W-1:0] d, input int id, input logic l);
      beat_t b;
      b.data = d;
      b.id   = IDW'(id);
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic push_job(input int id, input logic [W-1:0] off, input logic [W-1:0] xm,
                           input logic [W-1:0] xs, input logic [W-1:0] ym, input logic [W-1:0] ys);
      logic [W-1:0] a;
      for (int y = 0; y < int'(ym); y++)
         for (int x = 0; x < int'(xm); x++) begin
            a = off + W'(x) * xs + W'(y) * ys;
            push_beat(a, id, (x == int'(xm) - 1) && (y == int'(ym) - 1));
         end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.req_valid  = '1;
      bus.addr_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready);
      else n_pass++;
      n_total++;
      if ({bus.addr_valid, bus.addr_last, busy} !== 3'b000)
         $display("FAIL reset_flags: got valid/last/busy %b expected 000", {bus.addr_valid, bus.addr_last, busy});
      else n_pass++;
      n_total++;
      if (bus.addr_data !== 16'h0 || bus.addr_id !== 1'b0)
         $display("FAIL reset_data_id: got %h/%0d expected 0000/0", bus.addr_data, bus.addr_id);
      else n_pass++;
      bus.req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_single;
      beat_t e;
      int k = 0, first_c = 0, last_c = 0;
      @(negedge clk);
      bus.addr_ready = 1'b1;
      set_req(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      push_job(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      #1;
      n_total++;
      if (bus.req_ready !== 2'b01) $display("FAIL single_grant: got %b expected 01", bus.req_ready);
      else n_pass++;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         bus.req_valid[0] = 1'b0;
         #1;
         if (bus.addr_valid && bus.addr_ready) begin
            k++;
            if (k == 1) first_c = c;
            last_c = c;
            n_total++;
            if (exp_q.size() == 0) $display("FAIL single_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL single_beat: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
         if (c == 6) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL single_busy_run: got %b expected 1", busy);
            else n_pass++;
         end
         if (c == 7) begin
            n_total++;
            if ({busy, bus.addr_valid} !== 2'b00)
               $display("FAIL single_idle_after: got busy/valid %b expected 00", {busy, bus.addr_valid});
            else n_pass++;
         end
      end
      n_total++;
      if (k != 6 || first_c != 1 || last_c != 6)
         $display("FAIL single_timing: got beats %0d first %0d last %0d expected 6 1 6", k, first_c, last_c);
      else n_pass++;
   endtask

   task automatic test_backpressure;
      beat_t e;
      int k = 0;
      logic prev_stall = 1'b0;
      logic [W-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      @(negedge clk);
      set_req(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      push_job(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.req_valid[0] = 1'b0;
         bus.addr_ready = ((c - 1) % 3 == 0);
         #1;
         if (prev_stall) begin
            n_total++;
            if (!bus.addr_valid || bus.addr_data !== prev_data || bus.addr_last !== prev_last)
               $display("FAIL bp_hold: got valid %b data %h last %b expected 1 %h %b",
                        bus.addr_valid, bus.addr_data, bus.addr_last, prev_data, prev_last);
            else n_pass++;
         end
         prev_stall = bus.addr_valid && !bus.addr_ready;
         prev_data  = bus.addr_data;
         prev_last  = bus.addr_last;
         if (bus.addr_valid && bus.addr_ready) begin
            k++;
            n_total++;
            if (exp_q.size() == 0) $display("FAIL bp_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL bp_beat: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (k != 6 || exp_q.size() != 0) $display("FAIL bp_count: got %0d beats expected 6", k);
      else n_pass++;
      bus.addr_ready = 1'b1;
   endtask

   task automatic test_round_robin;
      beat_t e;
      int acc = 0, last_acc_c = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.addr_ready = 1'b1;
      set_req(0, 16'h0010, 16'd2, 16'd1, 16'd1, 16'd0);
      set_req(1, 16'h0020, 16'd2, 16'd1, 16'd1, 16'd0);
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) @(negedge clk);
         if (acc == 4) bus.req_valid = '0;
         #1;
         if (bus.req_ready !== 2'b00) begin
            n_total++;
            if (bus.req_ready !== (2'b01 << (acc % 2)) || bus.addr_valid !== 1'b0)
               $display("FAIL rr_grant: got ready %b valid %b expected %b 0",
                        bus.req_ready, bus.addr_valid, 2'b01 << (acc % 2));
            else n_pass++;
            if (acc > 0) begin
               n_total++;
               if (c - last_acc_c != 3) $display("FAIL rr_gap: got %0d cycles expected 3", c - last_acc_c);
               else n_pass++;
            end
            push_job(acc % 2, (acc % 2 == 1) ? 16'h0020 : 16'h0010, 16'd2, 16'd1, 16'd1, 16'd0);
            last_acc_c = c;
            acc++;
         end
         if (bus.addr_valid && bus.addr_ready) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL rr_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL rr_beat: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (acc != 4 || exp_q.size() != 0)
         $display("FAIL rr_count: got %0d grants %0d pending expected 4 0", acc, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_zero_size;
      beat_t e;
      @(negedge clk);
      set_req(1, 16'h0077, 16'd0, 16'd1, 16'd1, 16'd0);
      #1;
      n_total++;
      if (bus.req_ready !== 2'b10) $display("FAIL zero_grant: got %b expected 10", bus.req_ready);
      else n_pass++;
      @(negedge clk);
      set_req(0, 16'h0055, 16'd1, 16'd1, 16'd1, 16'd0);
      set_req(1, 16'h0066, 16'd2, 16'd1, 16'd1, 16'd0);
      #1;
      n_total++;
      if ({bus.req_ready, bus.addr_valid, busy} !== 4'b0100)
         $display("FAIL zero_next: got ready/valid/busy %b expected 0100", {bus.req_ready, bus.addr_valid, busy});
      else n_pass++;
      push_job(0, 16'h0055, 16'd1, 16'd1, 16'd1, 16'd0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         if (bus.addr_valid && bus.addr_ready) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL zero_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL zero_beat: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL zero_pending: got %0d expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_wrap;
      beat_t e;
      @(negedge clk);
      set_req(0, 16'hFFFF, 16'd2, 16'd1, 16'd2, 16'h8000);
      push_beat(16'hFFFF, 0, 1'b0);
      push_beat(16'h0000, 0, 1'b0);
      push_beat(16'h7FFF, 0, 1'b0);
      push_beat(16'h8000, 0, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         if (bus.addr_valid && bus.addr_ready) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL wrap_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL wrap_beat: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL wrap_pending: got %0d expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_job;
      beat_t e;
      int k = 0, lasts = 0;
      @(negedge clk);
      set_req(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      push_job(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      for (int c = 1; c <= 10 && k < 3; c++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         if (bus.addr_valid && bus.addr_ready) begin
            k++;
            if (bus.addr_last) lasts++;
            n_total++;
            e = exp_q.pop_front();
            if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
               $display("FAIL rstmid_beat: got %h id %0d last %b expected %h id %0d last %b",
                        bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
            else n_pass++;
            if (k == 3) rst = 1'b1;
         end
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({bus.addr_valid, busy, bus.addr_last} !== 3'b000 || lasts != 0)
         $display("FAIL rstmid_abort: got valid/busy/last %b lasts %0d expected 000 0",
                  {bus.addr_valid, busy, bus.addr_last}, lasts);
      else n_pass++;
      @(negedge clk);
      set_req(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      push_job(0, 16'd100, 16'd3, 16'd1, 16'd2, 16'd4);
      k = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         if (bus.addr_valid && bus.addr_ready) begin
            k++;
            n_total++;
            if (exp_q.size() == 0) $display("FAIL rstmid_extra_beat: got %h expected none", bus.addr_data);
            else begin
               e = exp_q.pop_front();
               if ({bus.addr_data, bus.addr_id, bus.addr_last} !== e)
                  $display("FAIL rstmid_restart: got %h id %0d last %b expected %h id %0d last %b",
                           bus.addr_data, bus.addr_id, bus.addr_last, e.data, e.id, e.last);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (k != 6) $display("FAIL rstmid_count: got %0d beats expected 6", k);
      else n_pass++;
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = '0;
      bus.req_offset   = '0;
      bus.req_x_max    = '0;
      bus.req_x_stride = '0;
      bus.req_y_max    = '0;
      bus.req_y_stride = '0;
      bus.addr_ready   = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_zero_size();
      test_wrap();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
